apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB initiator that turns a simple valid/ready request port into APB SETUP/ACCESS transfers.
- Completes one transfer at a time and returns read data and error on a valid/ready response port.
- Lets a core, test sequencer or DMA drive APB peripherals such as the timer without hand-built bus timing.

Parameters:
- APB_ADDR_WIDTH, 9, width of PADDR and req_addr_i
- APB_DATA_WIDTH, 32, width of PWDATA, PRDATA, req_wdata_i and rsp_rdata_o
- TIMEOUT_CYCLES, 255, ACCESS wait-cycle limit; used only with the optional feature; must be >= 1

Ports:
- HCLK  input  1  clock; all state updates on rising edge
- HRESET  input  1  asynchronous reset, active-high
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid & ready
- req_write_i  input  1  1 = write, 0 = read
- req_addr_i  input  APB_ADDR_WIDTH  transfer address
- req_wdata_i  input  APB_DATA_WIDTH  write data
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed when valid & ready
- rsp_rdata_o  output  APB_DATA_WIDTH  read data; 0 for writes
- rsp_error_o  output  1  PSLVERR captured, or timeout
- PADDR  output  APB_ADDR_WIDTH  APB address
- PWDATA  output  APB_DATA_WIDTH  APB write data
- PWRITE  output  1  APB direction
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PRDATA  input  APB_DATA_WIDTH  APB read data
- PREADY  input  1  APB ready
- PSLVERR  input  1  APB slave error

Behaviour:
- Reset: state IDLE; all outputs 0, except req_ready_o = 1, which is decoded from IDLE.
  - Asserting HRESET mid-transfer drops PSEL/PENABLE immediately (asynchronously) and discards any pending response.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs except req_ready_o are registered.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, register addr, wdata and write into PADDR/PWDATA/PWRITE, then go to SETUP.
- SETUP: PSEL = 1, PENABLE = 0, held for exactly one cycle, then ACCESS.
- ACCESS: PSEL = 1, PENABLE = 1.
  - PADDR, PWDATA and PWRITE stay stable.
  - While PREADY = 0, stay in ACCESS.
  - When PREADY = 1:
    - Capture PRDATA into rsp_rdata_o on reads; drive 0 on writes.
    - Capture PSLVERR into rsp_error_o.
    - Clear PSEL and PENABLE, go to RESP.
  - PSLVERR is sampled only in the PREADY = 1 ACCESS cycle.
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_error_o held.
  - On rsp_ready_i, go to IDLE and clear rsp_valid_o.
  - No new request is accepted until the following IDLE cycle.
- Minimum latency (zero-wait slave, rsp_ready_i tied 1): accept edge at cycle 0, SETUP cycle 1, ACCESS cycle 2, rsp_valid_o high in cycle 3, next accept in cycle 4.
- Between transfers, PADDR/PWDATA/PWRITE keep their last values (no toggling); PSEL = 0.
- req_* inputs are ignored outside IDLE. A request held valid across RESP is accepted only in IDLE.
- PSEL and PENABLE never rise in the same cycle. PENABLE = 1 implies PSEL = 1.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entering ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When the count reaches TIMEOUT_CYCLES with PREADY still 0, the transfer is aborted: PSEL/PENABLE cleared, rsp_rdata_o = 0, rsp_error_o = 1, go to RESP.
  - If PREADY = 1 in the same cycle the limit is reached, PREADY wins and the normal completion applies.
  - Counter width is $clog2(TIMEOUT_CYCLES + 1).
- Undefined: no counter logic; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_master_pkg:
  - State enum typedef apb_state_e {IDLE, SETUP, ACCESS, RESP}, 2-bit.
  - Default width localparams.
  - Response struct typedef (rdata, error).
- Sub-module apb_master_timeout: counter plus expiry compare. Instantiated only under APB_MASTER_TIMEOUT_EN.
- The FSM stays in apb_master.

Test Plan:
- Write, zero-wait: req addr 0x010, wdata 0xDEADBEEF, PREADY = 1 -> PSEL at cycle 1, PENABLE at cycle 2 with PADDR 0x010 and PWDATA 0xDEADBEEF stable; rsp_valid_o at cycle 3 with rsp_error_o 0 and rsp_rdata_o 0.
- Read, 3 wait states: addr 0x004, PREADY low 3 ACCESS cycles, PRDATA 0x12345678 -> ACCESS lasts 4 cycles; rsp_rdata_o 0x12345678 at cycle 6.
- Slave error: read with PSLVERR = 1 and PREADY = 1 -> rsp_error_o 1; PSLVERR pulsed during SETUP only -> rsp_error_o 0.
- Back-pressure: two queued requests, rsp_ready_i held low 5 cycles -> response stable for 5 cycles, req_ready_o 0; second transfer SETUP starts 2 cycles after the response handshake.
- Timeout (macro on, TIMEOUT_CYCLES = 4): PREADY held 0 -> abort after 4 wait cycles with rsp_error_o 1 and rsp_rdata_o 0; PREADY raised on the 4th wait cycle -> normal completion, no error.
- Reset mid-ACCESS: assert HRESET while PENABLE = 1 -> PSEL/PENABLE 0 the same cycle (asynchronous); after release, req_ready_o 1, no stale rsp_valid_o.

Source files
------------

// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared state encoding, default widths and response record for the APB initiator
package apb_master_pkg;
  localparam int DEF_ADDR_WIDTH = 9;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} apb_state_e;
  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] rdata;
    logic                      error;
  } apb_rsp_t;
endpackage

// File: rtl/apb_master_timeout.sv
// apb_master_timeout: ACCESS wait counter with expiry flag, used only when APB_MASTER_TIMEOUT_EN is defined
module apb_master_timeout #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : cnt + CW'(inc);
  // this wait cycle would bring the count up to LIMIT
  assign expired = inc && (cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/apb_master.sv
// apb_master: valid/ready request to APB SETUP/ACCESS initiator, one transfer at a time
// Optional ACCESS timeout abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int APB_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_error_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);
  apb_state_e                state_q, state_d;
  apb_rsp_t                  rsp_q, rsp_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_d;
  logic                      pwrite_d, psel_d, penable_d, rsp_valid_d, expired;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  apb_master_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (HCLK),
    .rst     (HRESET),
    .clr     (state_q != ACCESS),
    .inc     (state_q == ACCESS && !PREADY),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  assign req_ready_o = (state_q == IDLE);
  assign rsp_rdata_o = APB_DATA_WIDTH'(rsp_q.rdata);
  assign rsp_error_o = rsp_q.error;

  always_comb begin
    state_d     = state_q;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    pwrite_d    = PWRITE;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    rsp_valid_d = rsp_valid_o;
    rsp_d       = rsp_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        state_d  = SETUP;
        paddr_d  = req_addr_i;
        pwdata_d = req_wdata_i;
        pwrite_d = req_write_i;
        psel_d   = 1'b1;
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: if (PREADY || expired) begin
        state_d     = RESP;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        // a timeout abort only happens with PREADY low, so PREADY alone picks the outcome
        rsp_d.rdata = (PREADY && !PWRITE) ? DEF_DATA_WIDTH'(PRDATA) : '0;
        rsp_d.error = PREADY ? PSLVERR : 1'b1;
      end
      RESP: if (rsp_ready_i) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET)
    if (HRESET) begin
      state_q     <= IDLE;
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PWRITE      <= pwrite_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed self-checking bench for apb_master (timeout scenario when APB_MASTER_TIMEOUT_EN is defined)
module tb_apb_master;
  logic        HCLK = 1'b0, HRESET = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_error;
  logic [31:0] rsp_rdata;
  logic [8:0]  PADDR;
  logic [31:0] PWDATA, PRDATA = '0;
  logic        PWRITE, PSEL, PENABLE, PREADY = 1'b0, PSLVERR = 1'b0;
  int          total = 0, bad = 0;

  always #5 HCLK = ~HCLK;

  apb_master #(.APB_ADDR_WIDTH(9), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic req(input logic w, input logic [8:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    total++; if ({PSEL, PENABLE, rsp_valid, rsp_error, PWRITE} !== 5'b0) begin bad++; $display("FAIL rst_ctrl got=%b exp=00000", {PSEL, PENABLE, rsp_valid, rsp_error, PWRITE}); end
    total++; if ({PADDR, PWDATA, rsp_rdata} !== '0) begin bad++; $display("FAIL rst_data got=%h/%h/%h exp=0", PADDR, PWDATA, rsp_rdata); end
    HRESET = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait;
    PREADY = 1'b1;
    rsp_ready = 1'b1;
    req(1'b1, 9'h010, 32'hDEADBEEF);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL wr_accept got=%b exp=1", req_ready); end
    tick();
    req_valid = 1'b0;
    total++; if ({PSEL, PENABLE} !== 2'b10 || PADDR !== 9'h010) begin bad++; $display("FAIL wr_setup got=%b addr=%h exp=10 addr=010", {PSEL, PENABLE}, PADDR); end
    tick();
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b111) begin bad++; $display("FAIL wr_access got=%b exp=111", {PSEL, PENABLE, PWRITE}); end
    total++; if (PADDR !== 9'h010 || PWDATA !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_access_data got=%h/%h exp=010/deadbeef", PADDR, PWDATA); end
    tick();
    total++; if ({rsp_valid, rsp_error, PSEL, PENABLE} !== 4'b1000 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL wr_resp got=%b rdata=%h exp=1000 rdata=0", {rsp_valid, rsp_error, PSEL, PENABLE}, rsp_rdata); end
    tick();
    total++; if ({rsp_valid, req_ready} !== 2'b01 || PADDR !== 9'h010) begin bad++; $display("FAIL wr_idle got=%b addr=%h exp=01 addr=010", {rsp_valid, req_ready}, PADDR); end
  endtask

  task automatic test_read_wait;
    PREADY = 1'b0;
    PRDATA = 32'hAAAA5555;
    req(1'b0, 9'h004, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin bad++; $display("FAIL rd_wait%0d got=%b exp=110", i, {PSEL, PENABLE, rsp_valid}); end
      tick();
    end
    PREADY = 1'b1;
    PRDATA = 32'h12345678;
    total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin bad++; $display("FAIL rd_last_access got=%b exp=110", {PSEL, PENABLE, rsp_valid}); end
    tick();
    PREADY = 1'b0;
    PRDATA = 32'h0;
    total++; if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'h12345678) begin bad++; $display("FAIL rd_resp got=%b rdata=%h exp=10 rdata=12345678", {rsp_valid, rsp_error}, rsp_rdata); end
    tick();
  endtask

  task automatic test_slave_error;
    PREADY = 1'b1;
    PSLVERR = 1'b1;
    PRDATA = 32'h0BADF00D;
    req(1'b0, 9'h008, 32'h0);
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    total++; if ({rsp_valid, rsp_error} !== 2'b11 || rsp_rdata !== 32'h0BADF00D) begin bad++; $display("FAIL err_resp got=%b rdata=%h exp=11 rdata=0badf00d", {rsp_valid, rsp_error}, rsp_rdata); end
    tick();
    PSLVERR = 1'b0;
    req(1'b0, 9'h00C, 32'h0);
    tick();
    req_valid = 1'b0;
    PSLVERR = 1'b1;
    tick();
    PSLVERR = 1'b0;
    tick();
    total++; if ({rsp_valid, rsp_error} !== 2'b10) begin bad++; $display("FAIL err_setup_only got=%b exp=10", {rsp_valid, rsp_error}); end
    tick();
  endtask

  task automatic test_back_to_back;
    PREADY = 1'b1;
    PRDATA = 32'hCAFEF00D;
    rsp_ready = 1'b0;
    req(1'b0, 9'h020, 32'h0);
    tick();
    req(1'b1, 9'h030, 32'h55AA55AA);
    repeat (2) tick();
    PRDATA = 32'h0;
    for (int i = 0; i < 5; i++) begin
      total++; if ({rsp_valid, req_ready, PSEL} !== 3'b100 || rsp_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL bp_hold%0d got=%b rdata=%h exp=100 rdata=cafef00d", i, {rsp_valid, req_ready, PSEL}, rsp_rdata); end
      total++; if (PADDR !== 9'h020) begin bad++; $display("FAIL bp_addr%0d got=%h exp=020", i, PADDR); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    total++; if ({rsp_valid, req_ready, PSEL} !== 3'b010) begin bad++; $display("FAIL bp_idle got=%b exp=010", {rsp_valid, req_ready, PSEL}); end
    tick();
    req_valid = 1'b0;
    total++; if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 9'h030 || PWDATA !== 32'h55AA55AA) begin bad++; $display("FAIL bp_second_setup got=%b addr=%h wdata=%h exp=101 addr=030 wdata=55aa55aa", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA); end
    repeat (2) tick();
    total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL bp_second_resp got=%b rdata=%h exp=1 rdata=0", rsp_valid, rsp_rdata); end
    tick();
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout;
    PREADY = 1'b0;
    PRDATA = 32'h77777777;
    rsp_ready = 1'b1;
    req(1'b0, 9'h040, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin bad++; $display("FAIL to_wait%0d got=%b exp=110", i, {PSEL, PENABLE, rsp_valid}); end
      tick();
    end
    total++; if ({rsp_valid, rsp_error, PSEL, PENABLE} !== 4'b1100 || rsp_rdata !== 32'h0) begin bad++; $display("FAIL to_abort got=%b rdata=%h exp=1100 rdata=0", {rsp_valid, rsp_error, PSEL, PENABLE}, rsp_rdata); end
    tick();
    req(1'b0, 9'h044, 32'h0);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    PREADY = 1'b1;
    total++; if ({PSEL, PENABLE} !== 2'b11) begin bad++; $display("FAIL to_edge_access got=%b exp=11", {PSEL, PENABLE}); end
    tick();
    PREADY = 1'b0;
    total++; if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'h77777777) begin bad++; $display("FAIL to_edge_resp got=%b rdata=%h exp=10 rdata=77777777", {rsp_valid, rsp_error}, rsp_rdata); end
    tick();
  endtask
`else
  task automatic test_no_timeout;
    PREADY = 1'b0;
    rsp_ready = 1'b1;
    req(1'b0, 9'h040, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin bad++; $display("FAIL wait_forever%0d got=%b exp=110", i, {PSEL, PENABLE, rsp_valid}); end
      tick();
    end
    PREADY = 1'b1;
    PRDATA = 32'h13579BDF;
    tick();
    PREADY = 1'b0;
    total++; if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'h13579BDF) begin bad++; $display("FAIL wait_forever_resp got=%b rdata=%h exp=10 rdata=13579bdf", {rsp_valid, rsp_error}, rsp_rdata); end
    tick();
  endtask
`endif

  task automatic test_reset_mid;
    PREADY = 1'b0;
    rsp_ready = 1'b1;
    req(1'b1, 9'h050, 32'h00000001);
    tick();
    req_valid = 1'b0;
    tick();
    total++; if ({PSEL, PENABLE} !== 2'b11) begin bad++; $display("FAIL rm_access got=%b exp=11", {PSEL, PENABLE}); end
    #2 HRESET = 1'b1;
    #1;
    total++; if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin bad++; $display("FAIL rm_async_drop got=%b exp=000", {PSEL, PENABLE, rsp_valid}); end
    tick();
    HRESET = 1'b0;
    PREADY = 1'b1;
    total++; if ({req_ready, rsp_valid} !== 2'b10) begin bad++; $display("FAIL rm_release got=%b exp=10", {req_ready, rsp_valid}); end
    tick();
    total++; if ({req_ready, rsp_valid, PSEL} !== 3'b100) begin bad++; $display("FAIL rm_no_stale got=%b exp=100", {req_ready, rsp_valid, PSEL}); end
    PREADY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_slave_error();
    test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
